fractal_pixel_engine: RTL and testbench

// Parametrised escape-time fractal pixel generator (Mandelbrot; Julia optional). Steps a pixel grid

---
 rtl/fractal_pixel_engine_if.sv | 17 +
 rtl/fractal_pixel_engine.sv | 215 +++++++++++++++++++++
 tb/tb_fractal_pixel_engine.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fractal_pixel_engine_if.sv
// fractal_pixel_engine_if: AXI4-Stream pixel channel between the engine and its sink.
//   tdata  32  {8'h00,R,G,B} colour word
//   tkeep  4   byte enables (always all ones)
//   tlast  1   last pixel of a line
//   tuser  1   first pixel of a frame
//   tvalid 1   beat valid
//   tready 1   sink ready (driven by the sink)
interface fractal_pixel_engine_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;
    modport master(output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave(input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/fractal_pixel_engine.sv
// fractal_pixel_engine: escape-time Mandelbrot (optionally Julia) pixel generator, one iteration
// per clock, one colour word per pixel on an AXI4-Stream master with full back-pressure.
// Optional feature macro: JULIA_MODE_EN (adds cfg_julia_i/cfg_jre_i/cfg_jim_i and Julia mode).
// Ports:
//   aclk_i, areset_i          clock, asynchronous active-high reset
//   enable_i                  level; start/continue frames
//   cfg_re_start_i/im_start_i coordinate of pixel (0,0)
//   cfg_re_step_i/im_step_i   per-pixel / per-line increments
//   cfg_max_iter_i            iteration limit
//   cfg_julia_i, cfg_jre_i, cfg_jim_i  Julia select and constant (JULIA_MODE_EN only)
//   out_stream                AXI4-Stream master (tdata/tkeep/tlast/tuser/tvalid/tready)
//   busy_o                    engine not idle
//   frame_done_o              pulse on the last-pixel handshake
module fractal_pixel_engine #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 8,
    parameter int ITER_W = 8,
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic                     aclk_i,
    input  logic                     areset_i,
    input  logic                     enable_i,
    input  logic signed [DATA_W-1:0] cfg_re_start_i,
    input  logic signed [DATA_W-1:0] cfg_im_start_i,
    input  logic signed [DATA_W-1:0] cfg_re_step_i,
    input  logic signed [DATA_W-1:0] cfg_im_step_i,
    input  logic [ITER_W-1:0]        cfg_max_iter_i,
`ifdef JULIA_MODE_EN
    input  logic                     cfg_julia_i,
    input  logic signed [DATA_W-1:0] cfg_jre_i,
    input  logic signed [DATA_W-1:0] cfg_jim_i,
`endif
    fractal_pixel_engine_if.master   out_stream,
    output logic                     busy_o,
    output logic                     frame_done_o
);
    localparam int XW = X_SIZE > 1 ? $clog2(X_SIZE) : 1;
    localparam int YW = Y_SIZE > 1 ? $clog2(Y_SIZE) : 1;
    localparam logic [1:0] IDLE = 2'd0, INIT = 2'd1, ITER = 2'd2, OUT = 2'd3;
    localparam logic signed [DATA_W+1:0] LIMIT = (DATA_W+2)'(4 << FRAC_W);

    logic [1:0] state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic signed [DATA_W-1:0] re_q, re_d, im_q, im_d, zr_q, zr_d, zi_q, zi_d, cr_q, cr_d, ci_q, ci_d;
    logic signed [DATA_W-1:0] re_start_q, re_start_d, re_step_q, re_step_d, im_step_q, im_step_d;
    logic [ITER_W-1:0] n_q, n_d, max_iter_q, max_iter_d;
    logic [31:0] tdata_q, tdata_d;
    logic tlast_q, tlast_d, tuser_q, tuser_d;
`ifdef JULIA_MODE_EN
    logic julia_q, julia_d;
    logic signed [DATA_W-1:0] jre_q, jre_d, jim_q, jim_d;
`endif

    logic signed [2*DATA_W-1:0] zr_w, zi_w;
    logic signed [DATA_W-1:0] zr2, zi2, zi_n;
    logic signed [DATA_W+1:0] mag;
    logic [ITER_W+1:0] n3;
    logic [31:0] colour;
    logic escaped, last_x, last_y, hs, end_frame, relatch;

    // Full-width products, then floor shift back to the fixed-point scale.
    assign zr_w = {{DATA_W{zr_q[DATA_W-1]}}, zr_q};
    assign zi_w = {{DATA_W{zi_q[DATA_W-1]}}, zi_q};
    assign zr2 = DATA_W'((zr_w * zr_w) >>> FRAC_W);
    assign zi2 = DATA_W'((zi_w * zi_w) >>> FRAC_W);
    assign zi_n = DATA_W'(((zr_w * zi_w) <<< 1) >>> FRAC_W) + ci_q;
    // Two guard bits keep |z|^2 from overflowing before the compare.
    assign mag = {{2{zr2[DATA_W-1]}}, zr2} + {{2{zi2[DATA_W-1]}}, zi2};
    assign escaped = mag > LIMIT;
    assign n3 = {2'b00, n_q} + {1'b0, n_q, 1'b0};
    assign colour = {8'h00, 8'(n3), 8'({n_q, 1'b0}), 8'(n_q)};

    assign last_x = x_q == XW'(X_SIZE - 1);
    assign last_y = y_q == YW'(Y_SIZE - 1);
    assign hs = state_q == OUT && out_stream.tready;
    assign end_frame = hs && last_x && last_y;
    assign relatch = (state_q == IDLE || end_frame) && enable_i;

    assign out_stream.tdata = tdata_q;
    assign out_stream.tkeep = 4'hF;
    assign out_stream.tlast = tlast_q;
    assign out_stream.tuser = tuser_q;
    assign out_stream.tvalid = state_q == OUT;
    assign busy_o = state_q != IDLE;
    assign frame_done_o = end_frame;

    always_comb begin
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        re_d = re_q;
        im_d = im_q;
        zr_d = zr_q;
        zi_d = zi_q;
        cr_d = cr_q;
        ci_d = ci_q;
        n_d = n_q;
        tdata_d = tdata_q;
        tlast_d = tlast_q;
        tuser_d = tuser_q;
        re_start_d = re_start_q;
        re_step_d = re_step_q;
        im_step_d = im_step_q;
        max_iter_d = max_iter_q;
`ifdef JULIA_MODE_EN
        julia_d = julia_q;
        jre_d = jre_q;
        jim_d = jim_q;
`endif
        if (state_q == IDLE && enable_i) state_d = INIT;
        if (state_q == INIT) begin
            state_d = ITER;
            n_d = '0;
`ifdef JULIA_MODE_EN
            zr_d = julia_q ? re_q : '0;
            zi_d = julia_q ? im_q : '0;
            cr_d = julia_q ? jre_q : re_q;
            ci_d = julia_q ? jim_q : im_q;
`else
            zr_d = '0;
            zi_d = '0;
            cr_d = re_q;
            ci_d = im_q;
`endif
        end
        if (state_q == ITER) begin
            if (escaped || n_q == max_iter_q) begin
                state_d = OUT;
                tdata_d = escaped ? colour : 32'h0;
                tlast_d = last_x;
                tuser_d = x_q == '0 && y_q == '0;
            end else begin
                zr_d = zr2 - zi2 + cr_q;
                zi_d = zi_n;
                n_d = n_q + ITER_W'(1);
            end
        end
        // Coordinates advance by accumulation only; x rewinds to re_start each line.
        if (hs) begin
            x_d = last_x ? '0 : x_q + XW'(1);
            y_d = last_x ? (last_y ? '0 : y_q + YW'(1)) : y_q;
            re_d = last_x ? re_start_q : re_q + re_step_q;
            im_d = last_x ? im_q + im_step_q : im_q;
            state_d = end_frame && !enable_i ? IDLE : INIT;
        end
        // Configuration is sampled only at frame start so a frame is self-consistent.
        if (relatch) begin
            re_start_d = cfg_re_start_i;
            re_step_d = cfg_re_step_i;
            im_step_d = cfg_im_step_i;
            max_iter_d = cfg_max_iter_i;
            re_d = cfg_re_start_i;
            im_d = cfg_im_start_i;
            x_d = '0;
            y_d = '0;
`ifdef JULIA_MODE_EN
            julia_d = cfg_julia_i;
            jre_d = cfg_jre_i;
            jim_d = cfg_jim_i;
`endif
        end
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            state_q <= IDLE;
            x_q <= '0;
            y_q <= '0;
            re_q <= '0;
            im_q <= '0;
            zr_q <= '0;
            zi_q <= '0;
            cr_q <= '0;
            ci_q <= '0;
            n_q <= '0;
            tdata_q <= '0;
            tlast_q <= 1'b0;
            tuser_q <= 1'b0;
            re_start_q <= '0;
            re_step_q <= '0;
            im_step_q <= '0;
            max_iter_q <= '0;
`ifdef JULIA_MODE_EN
            julia_q <= 1'b0;
            jre_q <= '0;
            jim_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            re_q <= re_d;
            im_q <= im_d;
            zr_q <= zr_d;
            zi_q <= zi_d;
            cr_q <= cr_d;
            ci_q <= ci_d;
            n_q <= n_d;
            tdata_q <= tdata_d;
            tlast_q <= tlast_d;
            tuser_q <= tuser_d;
            re_start_q <= re_start_d;
            re_step_q <= re_step_d;
            im_step_q <= im_step_d;
            max_iter_q <= max_iter_d;
`ifdef JULIA_MODE_EN
            julia_q <= julia_d;
            jre_q <= jre_d;
            jim_q <= jim_d;
`endif
        end
    end
endmodule

// File: tb/tb_fractal_pixel_engine.sv
// tb_fractal_pixel_engine: directed bench with a behavioural escape-time model and a beat scoreboard.
module tb_fractal_pixel_engine;
    localparam int XS = 4, YS = 2;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic signed [31:0] re_s = 0, im_s = 0, re_st = 0, im_st = 0;
    logic [7:0] mx = 8'd16;
`ifdef JULIA_MODE_EN
    logic jul = 1'b0;
    logic signed [31:0] jre = 0, jim = 0;
`endif
    logic busy, fd;
    int tr_mode = 0;
    int errs = 0, checks = 0, beats = 0, fds = 0;

    typedef struct packed {logic [31:0] d; logic l; logic u; logic f;} beat_t;
    beat_t q[$];
    beat_t e;
    logic prev_stall = 1'b0;
    logic [33:0] prev_out;

    always #5 clk = ~clk;

    fractal_pixel_engine_if s();

    fractal_pixel_engine #(.DATA_W(32), .FRAC_W(8), .ITER_W(8), .X_SIZE(XS), .Y_SIZE(YS)) dut (
        .aclk_i(clk), .areset_i(rst), .enable_i(en),
        .cfg_re_start_i(re_s), .cfg_im_start_i(im_s), .cfg_re_step_i(re_st), .cfg_im_step_i(im_st),
        .cfg_max_iter_i(mx),
`ifdef JULIA_MODE_EN
        .cfg_julia_i(jul), .cfg_jre_i(jre), .cfg_jim_i(jim),
`endif
        .out_stream(s.master), .busy_o(busy), .frame_done_o(fd)
    );

    always @(posedge clk) begin
        #1;
        s.tready = tr_mode == 0 ? 1'b1 : tr_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
    end

    function automatic logic [31:0] colour(int cr, int ci, int zr0, int zi0, int mi);
        int zr = zr0, zi = zi0;
        for (int n = 0; n < 256; n++) begin
            int a, b, t;
            a = int'((longint'(zr) * zr) >>> 8);
            b = int'((longint'(zi) * zi) >>> 8);
            if (longint'(a) + longint'(b) > 1024) return {8'h00, 8'(n * 3), 8'(n * 2), 8'(n)};
            if (n == mi) return 32'h0;
            t = a - b + cr;
            zi = int'((2 * longint'(zr) * zi) >>> 8) + ci;
            zr = t;
        end
        return 32'h0;
    endfunction

    task automatic push_frame(int rs, int is, int rstep, int istep, int mi, bit jm, int jr, int ji);
        for (int y = 0; y < YS; y++)
            for (int x = 0; x < XS; x++) begin
                int re, im;
                beat_t b;
                re = rs + x * rstep;
                im = is + y * istep;
                b.d = jm ? colour(jr, ji, re, im, mi) : colour(re, im, 0, 0, mi);
                b.l = x == XS - 1;
                b.u = x == 0 && y == 0;
                b.f = x == XS - 1 && y == YS - 1;
                q.push_back(b);
            end
    endtask

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start();
        int n = 0;
        @(posedge clk);
        #1 en = 1'b1;
        while (!busy && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        chk("start_busy", 64'(busy), 1);
    endtask

    task automatic latency(string nm, int exp);
        int n = 0;
        while (!s.tvalid && n < 400) begin
            @(posedge clk);
            #1 n++;
        end
        chk(nm, n, exp);
    endtask

    task automatic finish_frame();
        int n = 0;
        while (busy && n < 5000) begin
            @(posedge clk);
            #1 n++;
        end
        chk("frame_idle", 64'(busy), 0);
        chk("queue_drained", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) prev_stall <= 1'b0;
        else begin
            if (prev_stall) begin
                checks++;
                if ({s.tvalid, s.tdata, s.tlast, s.tuser} !== {1'b1, prev_out}) begin
                    errs++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b u=%b expected v=1 {d,l,u}=%h", s.tvalid, s.tdata, s.tlast, s.tuser, prev_out);
                end
            end
            prev_stall <= s.tvalid && !s.tready;
            prev_out <= {s.tdata, s.tlast, s.tuser};
            if (fd) fds++;
            if (s.tvalid && s.tready) begin
                beats++;
                checks++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL beat: unexpected beat tdata=%h", s.tdata);
                end else begin
                    e = q.pop_front();
                    if ({s.tdata, s.tlast, s.tuser, fd, s.tkeep} !== {e.d, e.l, e.u, e.f, 4'hF}) begin
                        errs++;
                        $display("FAIL beat: got d=%h l=%b u=%b fd=%b k=%h expected d=%h l=%b u=%b fd=%b k=f", s.tdata, s.tlast, s.tuser, fd, s.tkeep, e.d, e.l, e.u, e.f);
                    end
                end
            end
        end
    end

    initial begin
        int b0, f0, n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(s.tvalid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_tdata", 64'(s.tdata), 0);
        chk("rst_tlast_tuser", 64'({s.tlast, s.tuser}), 0);
        chk("rst_frame_done", 64'(fd), 0);
        rst = 1'b0;
        chk("model_inset", 64'(colour(0, 0, 0, 0, 16)), 0);
        chk("model_esc", 64'(colour(512, 0, 0, 0, 16)), 64'h00060402);
        chk("model_julia", 64'(colour(0, 0, 768, 0, 16)), 0);
        chk("model_n1", 64'(colour(1024, 0, 0, 0, 16)), 64'h00030201);
        // in-set pixel, 18 cycles INIT->OUT
        re_s = 0; im_s = 0; re_st = 0; im_st = 0; mx = 16;
        push_frame(0, 0, 0, 0, 16, 0, 0, 0);
        f0 = fds; b0 = beats;
        start();
        en = 1'b0;
        latency("lat_inset", 18);
        finish_frame();
        chk("inset_frame_done", fds - f0, 1);
        chk("inset_beats", beats - b0, 8);
        // escape at n=2
        re_s = 512;
        push_frame(512, 0, 0, 0, 16, 0, 0, 0);
        start();
        en = 1'b0;
        latency("lat_esc", 4);
        chk("esc_tdata", 64'(s.tdata), 64'h00060402);
        finish_frame();
        // two back-to-back frames; mid-frame cfg change lands in frame 2, random back-pressure
        re_s = -512; re_st = 256; im_s = -256; im_st = 256; mx = 20;
        push_frame(-512, -256, 256, 256, 20, 0, 0, 0);
        push_frame(-256, 0, 128, 64, 20, 0, 0, 0);
        f0 = fds; b0 = beats;
        start();
        re_s = -256; re_st = 128; im_s = 0; im_st = 64;
        n = 0;
        while (fds == f0 && n < 5000) begin
            @(posedge clk);
            #1 n++;
        end
        en = 1'b0;
        tr_mode = 1;
        finish_frame();
        tr_mode = 0;
        chk("two_frames_done", fds - f0, 2);
        chk("two_frames_beats", beats - b0, 16);
        // 10-cycle stall on the first beat
        tr_mode = 2;
        re_s = 0; re_st = 0; im_s = 0; im_st = 0; mx = 16;
        push_frame(0, 0, 0, 0, 16, 0, 0, 0);
        b0 = beats;
        start();
        en = 1'b0;
        latency("lat_stall", 18);
        repeat (10) @(posedge clk);
        #1;
        chk("stall_valid", 64'(s.tvalid), 1);
        chk("stall_no_beat", beats - b0, 0);
        tr_mode = 0;
        finish_frame();
        // max_iter=0: black after one ITER cycle
        re_s = 512; mx = 0;
        push_frame(512, 0, 0, 0, 0, 0, 0, 0);
        start();
        en = 1'b0;
        latency("lat_max0", 2);
        finish_frame();
        // asynchronous reset mid-ITER on pixel 3
        re_s = 0; mx = 16;
        push_frame(0, 0, 0, 0, 16, 0, 0, 0);
        b0 = beats;
        start();
        en = 1'b0;
        n = 0;
        while (beats - b0 < 3 && n < 2000) begin
            @(posedge clk);
            #1 n++;
        end
        chk("pre_reset_beats", beats - b0, 3);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_tvalid", 64'(s.tvalid), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_tdata", 64'(s.tdata), 0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        push_frame(0, 0, 0, 0, 16, 0, 0, 0);
        start();
        en = 1'b0;
        latency("lat_after_rst", 18);
        chk("after_rst_tuser", 64'(s.tuser), 1);
        finish_frame();
`ifdef JULIA_MODE_EN
        jul = 1'b1; jre = 0; jim = 0; re_s = 768; mx = 16;
        push_frame(768, 0, 0, 0, 16, 1, 0, 0);
        start();
        en = 1'b0;
        latency("lat_julia", 2);
        chk("julia_tdata", 64'(s.tdata), 0);
        finish_frame();
        jul = 1'b0;
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
